// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, state/class enums and watchdog limit for the fetch/dispatch FSM
package cpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_HALT   = 4'h1;
    localparam logic [3:0] OP_MOV_LO = 4'h2;
    localparam logic [3:0] OP_MOV_HI = 4'h8;
    localparam logic [3:0] OP_ALU_LO = 4'h9;
    localparam logic [3:0] OP_ALU_HI = 4'hF;

    localparam int WDOG_LIMIT = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_ADDR,
        MEM_RD,
        DECODE,
        EXEC_ALU,
        EXEC_MOV,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_HALT,
        CLS_ALU,
        CLS_MOV
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// rtl/op_class_decode.sv - combinational opcode classifier (IR[15:12] -> NOP/HALT/ALU/MOV)
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class
);

    // Anything not NOP, HALT or inside the MOV range falls into the ALU range (9..F).
    always_comb begin
        op_class = CLS_ALU;
        if (opcode == OP_NOP) begin
            op_class = CLS_NOP;
        end else if (opcode == OP_HALT) begin
            op_class = CLS_HALT;
        end else if ((opcode >= OP_MOV_LO) && (opcode <= OP_MOV_HI)) begin
            op_class = CLS_MOV;
        end
    end

endmodule

// File: rtl/fetch_dispatch_fsm.sv
// rtl/fetch_dispatch_fsm.sv - Moore fetch/decode/dispatch FSM; optional EXEC watchdog under FETCH_WDOG_EN
module fetch_dispatch_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        PC_out,
    output logic        MAR_in,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic [15:0] IR,
    output logic        pc_inc,
    output logic        alu_go,
    input  logic        alu_done,
    output logic        mov_go,
    input  logic        mov_done,
    output logic        halted,
    output logic        fault
);

    state_t    state;
    state_t    state_next;
    op_class_t op_class;
    logic      wdog_expire;
    logic      in_exec;

    assign in_exec = (state == EXEC_ALU) || (state == EXEC_MOV);

    op_class_decode u_op_class_decode (
        .opcode   (IR[15:12]),
        .op_class (op_class)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            IR    <= 16'h0000;
        end else begin
            state <= state_next;
            if ((state == MEM_RD) && mem_ready) begin
                IR <= mem_data;
            end
        end
    end

`ifdef FETCH_WDOG_EN
    logic [5:0] wdog_cnt;
    logic       fault_q;

    // Expiry fires in the 32nd EXEC cycle so go is held for exactly WDOG_LIMIT cycles.
    assign wdog_expire = (wdog_cnt == 6'(WDOG_LIMIT - 1));
    assign fault       = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= 6'd0;
            fault_q  <= 1'b0;
        end else begin
            if (state == DECODE) begin
                wdog_cnt <= 6'd0;
            end else if (in_exec) begin
                wdog_cnt <= wdog_cnt + 6'd1;
            end
            if (in_exec && (state_next == HALT)) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign fault       = 1'b0;
`endif

    always_comb begin
        state_next = state;
        PC_out     = 1'b0;
        MAR_in     = 1'b0;
        mem_rd     = 1'b0;
        pc_inc     = 1'b0;
        alu_go     = 1'b0;
        mov_go     = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH_ADDR;
            end
            FETCH_ADDR: begin
                PC_out     = 1'b1;
                MAR_in     = 1'b1;
                state_next = MEM_RD;
            end
            MEM_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                case (op_class)
                    CLS_NOP: begin
                        pc_inc     = 1'b1;
                        state_next = run ? FETCH_ADDR : IDLE;
                    end
                    CLS_HALT: state_next = HALT;
                    CLS_ALU:  state_next = EXEC_ALU;
                    default:  state_next = EXEC_MOV;
                endcase
            end
            EXEC_ALU: begin
                alu_go = 1'b1;
                if (alu_done)         state_next = run ? FETCH_ADDR : IDLE;
                else if (wdog_expire) state_next = HALT;
            end
            EXEC_MOV: begin
                mov_go = 1'b1;
                if (mov_done)         state_next = run ? FETCH_ADDR : IDLE;
                else if (wdog_expire) state_next = HALT;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// tb/tb_fetch_dispatch_fsm.sv - scoreboard bench for fetch_dispatch_fsm (watchdog case under FETCH_WDOG_EN)
module tb_fetch_dispatch_fsm;

    localparam int K_NOP  = 0;
    localparam int K_HALT = 1;
    localparam int K_ALU  = 2;
    localparam int K_MOV  = 3;

    typedef struct {
        int          kind;
        logic [15:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        PC_out, MAR_in, mem_rd, pc_inc, alu_go, mov_go, halted, fault;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] IR;
    logic        alu_done = 1'b0;
    logic        mov_done = 1'b0;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic p_alu = 1'b0, p_mov = 1'b0, p_halt = 1'b0;

    fetch_dispatch_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .PC_out    (PC_out),
        .MAR_in    (MAR_in),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .IR        (IR),
        .pc_inc    (pc_inc),
        .alu_go    (alu_go),
        .alu_done  (alu_done),
        .mov_go    (mov_go),
        .mov_done  (mov_done),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] ir);
        exp_t e;
        e.kind = kind;
        e.ir   = ir;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind %0d ir %0h expected nothing", kind, IR);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.ir !== IR)) begin
                n_fail++;
                $display("FAIL sb_event: got kind %0d ir %0h expected kind %0d ir %0h",
                         kind, IR, e.kind, e.ir);
            end
        end
    endtask

    // Monitor: every dispatch, NOP pc_inc pulse and HALT entry is one scoreboard event.
    always @(negedge clk) begin
        if (rst) begin
            if (alu_go && !p_alu) observe(K_ALU);
            if (mov_go && !p_mov) observe(K_MOV);
            if (pc_inc)           observe(K_NOP);
            if (halted && !p_halt) observe(K_HALT);
        end
        p_alu  = alu_go;
        p_mov  = mov_go;
        p_halt = halted;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_event(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (alu_go || mov_go || pc_inc || halted) break;
            step();
            cycles++;
        end
        chk("event_seen", {31'd0, (alu_go | mov_go | pc_inc | halted)}, 32'd1);
    endtask

    task automatic run_instr(input logic [15:0] word, input int kind);
        int c;
        push(kind, word);
        mem_data  = word;
        mem_ready = 1'b1;
        run       = 1'b1;
        step();
        run = 1'b0;
        wait_event(c);
        case (kind)
            K_ALU: begin
                chk("tbl_alu_go", {31'd0, alu_go}, 32'd1);
                alu_done = 1'b1;
                step();
                alu_done = 1'b0;
            end
            K_MOV: begin
                chk("tbl_mov_go", {31'd0, mov_go}, 32'd1);
                mov_done = 1'b1;
                step();
                mov_done = 1'b0;
            end
            default: begin
                chk("tbl_pc_inc", {31'd0, pc_inc}, 32'd1);
                step();
            end
        endcase
        step();
        chk("tbl_idle", {28'd0, PC_out, mem_rd, alu_go, mov_go}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int rd_cycles;
        int c;

        // Reset state and no departure from IDLE while run=0
        step();
        step();
        chk("rst_outputs", {24'd0, PC_out, MAR_in, mem_rd, pc_inc, alu_go, mov_go, halted, fault}, 32'd0);
        chk("rst_ir", {16'd0, IR}, 32'h0);
        rst = 1'b1;
        step();
        chk("idle_hold1", {30'd0, PC_out, MAR_in}, 32'd0);
        step();
        chk("idle_hold2", {30'd0, PC_out, mem_rd}, 32'd0);

        // Zero-wait ALU fetch, latency from run sample to alu_go
        run       = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 16'h9042;
        push(K_ALU, 16'h9042);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (lat == 1) chk("fa_strobes", {30'd0, PC_out, MAR_in}, 32'h3);
            if (lat == 2) chk("mr_strobes", {29'd0, PC_out, MAR_in, mem_rd}, 32'h1);
            if (alu_go) break;
        end
        chk("alu_latency", lat, 32'd4);
        chk("ir_9042", {16'd0, IR}, 32'h9042);
        mem_ready = 1'b0;
        mem_data  = 16'h2081;
        alu_done  = 1'b1;
        step();
        alu_done = 1'b0;
        chk("done_to_fa", {30'd0, PC_out, alu_go}, 32'h2);

        // Three wait states on memory, MOV dispatch, IR held until mov_done
        push(K_MOV, 16'h2081);
        step();
        rd_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd) rd_cycles++;
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        chk("mem_rd_cycles", rd_cycles, 32'd4);
        chk("decode_no_rd", {31'd0, mem_rd}, 32'd0);
        chk("ir_2081", {16'd0, IR}, 32'h2081);
        mem_ready = 1'b0;
        mem_data  = 16'hFFFF;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("mov_hold", {15'd0, mov_go, IR}, 32'h12081);
            step();
        end
        mem_data  = 16'h0000;
        mem_ready = 1'b1;
        mov_done  = 1'b1;
        step();
        mov_done = 1'b0;
        chk("ir_after_mov", {15'd0, PC_out, IR}, 32'h12081);

        // NOP then HALT; halted sticks while run toggles
        push(K_NOP, 16'h0000);
        step();
        step();
        chk("nop_pc_inc", {31'd0, pc_inc}, 32'd1);
        push(K_HALT, 16'h1000);
        mem_data = 16'h1000;
        step();
        chk("nop_pc_inc_gone", {30'd0, pc_inc, PC_out}, 32'h1);
        step();
        step();
        step();
        chk("halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            step();
            chk("halt_sticky", {29'd0, halted, PC_out, alu_go}, 32'h4);
        end

        // Asynchronous reset mid-EXEC_ALU
        rst = 1'b0;
        step();
        mem_data  = 16'hF123;
        mem_ready = 1'b1;
        run       = 1'b1;
        rst       = 1'b1;
        push(K_ALU, 16'hF123);
        wait_event(c);
        step();
        step();
        chk("exec_before_rst", {31'd0, alu_go}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_exec", {24'd0, PC_out, MAR_in, mem_rd, pc_inc, alu_go, mov_go, halted, fault}, 32'd0);
        chk("rst_mid_exec_ir", {16'd0, IR}, 32'h0);
        step();
        run = 1'b0;
        rst = 1'b1;
        step();
        chk("idle_after_rst", {30'd0, PC_out, alu_go}, 32'd0);

        // Foreign done ignored, run dropped mid-EXEC returns to IDLE
        run      = 1'b1;
        mem_data = 16'hA5A5;
        push(K_ALU, 16'hA5A5);
        step();
        wait_event(c);
        run      = 1'b0;
        mov_done = 1'b1;
        step();
        mov_done = 1'b0;
        chk("mov_done_ignored", {31'd0, alu_go}, 32'd1);
        step();
        chk("still_exec", {16'd0, alu_go, 15'd0}, 32'h8000);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("end_to_idle", {28'd0, PC_out, mem_rd, alu_go, mov_go}, 32'd0);
        step();
        chk("idle_stays", {30'd0, PC_out, MAR_in}, 32'd0);

        // Opcode class boundaries
        run_instr(16'h2000, K_MOV);
        run_instr(16'h8FFF, K_MOV);
        run_instr(16'h9000, K_ALU);
        run_instr(16'hFFFF, K_ALU);
        run_instr(16'h0ABC, K_NOP);

`ifdef FETCH_WDOG_EN
        push(K_ALU, 16'h9999);
        push(K_HALT, 16'h9999);
        mem_data = 16'h9999;
        run      = 1'b1;
        step();
        run = 1'b0;
        wait_event(c);
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!alu_go) break;
            lat++;
        end
        chk("wdog_cycles", lat, 32'd32);
        chk("wdog_state", {29'd0, fault, halted, alu_go}, 32'h6);
`else
        chk("fault_tied", {31'd0, fault}, 32'd0);
`endif

        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_dispatch_fsm.md
FETCH_DISPATCH_FSM -- requirements
Module: fetch_dispatch_fsm

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-002 SHALL have port `clk`: input, 1 bit, system clock, rising-edge.
REQ-003 SHALL have port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port `run`: input, 1 bit, start/continue instruction fetching.
REQ-005 SHALL have port `PC_out`: output, 1 bit, drives PC onto the address bus.
REQ-006 SHALL have port `MAR_in`: output, 1 bit, latches the bus into the memory address register.
REQ-007 SHALL have port `mem_rd`: output, 1 bit, memory read request.
REQ-008 SHALL have port `mem_ready`: input, 1 bit, memory data valid.
REQ-009 SHALL have port `mem_data`: input, 16 bits, instruction word from memory.
REQ-010 SHALL have port `IR`: output, 16 bits, latched instruction; feeds the fullBitNum input of the execute FSMs.
REQ-011 SHALL have port `pc_inc`: output, 1 bit, PC advance for NOP only.
REQ-012 SHALL have port `alu_go`: output, 1 bit, ALU instruction dispatched.
REQ-013 SHALL have port `alu_done`: input, 1 bit, ALU execute FSM finished (pulse).
REQ-014 SHALL have port `mov_go`: output, 1 bit, move/load instruction dispatched.
REQ-015 SHALL have port `mov_done`: input, 1 bit, move/load FSM finished (pulse).
REQ-016 SHALL have port `halted`: output, 1 bit, HALT executed.
REQ-017 SHALL have port `fault`: output, 1 bit, watchdog timeout, sticky.

Function
REQ-018 SHALL implement Moore FSM states IDLE, FETCH_ADDR, MEM_RD, DECODE, EXEC_ALU, EXEC_MOV, HALT; outputs decoded from present state only.
REQ-019 IDLE SHALL drive all strobes 0 and go to FETCH_ADDR on an edge with run=1.
REQ-020 FETCH_ADDR SHALL assert PC_out=1 and MAR_in=1 for exactly one cycle, then go to MEM_RD.
REQ-021 MEM_RD SHALL hold mem_rd=1 until mem_ready=1, load IR<=mem_data on that edge, then go to DECODE; mem_ready=1 in the first MEM_RD cycle SHALL be accepted (zero wait).
REQ-022 DECODE SHALL last one cycle and classify IR[15:12] as follows.
REQ-023 Opcode 1001-1111 SHALL go to EXEC_ALU.
REQ-024 Opcode 0010-1000 SHALL go to EXEC_MOV.
REQ-025 Opcode 0000 (NOP) SHALL assert pc_inc=1 in DECODE and go to FETCH_ADDR, or to IDLE if run=0.
REQ-026 Opcode 0001 SHALL go to HALT.
REQ-027 EXEC_ALU SHALL hold alu_go=1 and EXEC_MOV SHALL hold mov_go=1 until the matching done is sampled 1; next state is then FETCH_ADDR if run=1, else IDLE.
REQ-028 IR SHALL change only in MEM_RD on mem_ready; it SHALL stay stable through DECODE and EXEC states.
REQ-029 alu_done and mov_done SHALL be ignored outside their own EXEC state; the non-matching done inside an EXEC state SHALL be ignored.
REQ-030 run=0 during MEM_RD, DECODE or EXEC SHALL NOT abort the instruction; the FSM SHALL return to IDLE at instruction end.
REQ-031 HALT SHALL assert halted=1 and remain there until reset, regardless of run.
REQ-032 Latency with zero-wait memory: run sampled 1 in IDLE -> alu_go/mov_go asserted 4 cycles later (IDLE, FETCH_ADDR, MEM_RD, DECODE).

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, IR=16'h0000 and fault=0; all outputs SHALL be 0, including mid-fetch and mid-execute.
REQ-034 After rst deasserts, the FSM SHALL leave IDLE only on an edge with run=1.

Configuration
REQ-035 With macro FETCH_WDOG_EN defined, a 6-bit counter SHALL clear on EXEC entry and increment each EXEC cycle; at count 32 with no done, the FSM SHALL set fault=1, drop go, and enter HALT.
REQ-036 Without FETCH_WDOG_EN, EXEC states SHALL wait indefinitely and fault SHALL be tied 0.

Structure
REQ-037 Shared package cpu_pkg SHALL hold the opcode constants (NOP, HALT, ALU range, MOV range), the state enumeration, and WDOG_LIMIT=32.
REQ-038 Opcode classification SHALL be one combinational sub-module, op_class_decode (IR[15:12] -> class NOP/HALT/ALU/MOV).

Verification
REQ-039 Reset, run=1, mem_data=16'h9042, zero-wait memory -> PC_out/MAR_in one cycle, IR=16'h9042, alu_go 4 cycles after run sampled; alu_done pulse -> FETCH_ADDR next cycle.
REQ-040 mem_ready delayed 3 cycles, mem_data=16'h2081 -> mem_rd held 4 cycles, mov_go asserted, IR stable until mov_done.
REQ-041 mem_data=16'h0000 then 16'h1000 -> one pc_inc pulse, then halted=1 held despite run toggling.
REQ-042 rst=0 asserted while in EXEC_ALU -> all outputs 0 immediately, IR=0, state IDLE.
REQ-043 FETCH_WDOG_EN defined, ALU opcode, alu_done never asserted -> fault=1 after 32 EXEC cycles, alu_go=0, halted=1.
REQ-044 mov_done pulsed during EXEC_ALU, and run dropped mid-EXEC -> mov_done ignored; the instruction completes on alu_done and the FSM returns to IDLE.
